msg_receive_parser: RTL and testbench

- Downstream counterpart of the message transmit driver. Consumes the 128-bit message flow word-by-word: flow_valid_i / flow_data_i, one word per valid cycle, no backpressure.
- Validates the header and length fields, extracts the header fields, and forwards payload bytes as 128-bit words with byte enables into a wide payload FIFO.
- Verifies the trailing 8-bit additive checksum and reports a per-frame status pulse to the message-handling logic.

---
 rtl/msg_pkg.sv | 40 ++++
 rtl/msg_byte_sum16.sv | 16 +
 rtl/msg_receive_parser.sv | 193 +++++++++++++++++++
 tb/tb_msg_receive_parser.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message flow: header bit offsets, parser states,
// frame error bit indices and frame length arithmetic.
package msg_pkg;

    localparam logic [31:0] SYNC_HEADER_DEF = 32'hEB90_146F;

    localparam int HDR_SYNC_LSB  = 96;
    localparam int HDR_FLEN_LSB  = 80;
    localparam int HDR_TYPE_LSB  = 64;
    localparam int HDR_CNT_LSB   = 48;
    localparam int HDR_SRC_LSB   = 40;
    localparam int HDR_DES_LSB   = 32;
    localparam int HDR_DTYPE_LSB = 24;
    localparam int HDR_CHAN_LSB  = 16;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_BODY  = 2'd1,
        S_CHECK = 2'd2
    } state_e;

    localparam int ERR_CSUM = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_TMO  = 2;
    localparam int ERR_OVF  = 3;

    // frame_len field value implied by a data length (64-byte granules).
    function automatic logic [10:0] exp_frame_len(input logic [15:0] len);
        logic [16:0] s;
        s = {1'b0, len} + 17'd16;
        return s[16:6];
    endfunction

    // Total 128-bit words in a frame, header included.
    function automatic logic [18:0] frame_words(input logic [15:0] len);
        return ({8'd0, exp_frame_len(len)} + 19'd1) << 2;
    endfunction

endpackage

// File: rtl/msg_byte_sum16.sv
// Combinational 8-bit modulo sum of the byte lanes of a 128-bit word
// selected by lane_mask (bit k selects bits [8k+7:8k]).
module msg_byte_sum16 (
    input  logic [127:0] word,
    input  logic [15:0]  lane_mask,
    output logic [7:0]   sum
);

    always_comb begin
        sum = 8'd0;
        for (int k = 0; k < 16; k++) begin
            if (lane_mask[k]) sum = sum + word[8*k +: 8];
        end
    end

endmodule

// File: rtl/msg_receive_parser.sv
// Message flow receiver: header/length validation, payload forwarding, checksum.
// Optional destination filtering under macro MSG_RECV_DES_FILTER_EN.
module msg_receive_parser
    import msg_pkg::*;
#(
    parameter logic [31:0] SYNC_HEADER    = SYNC_HEADER_DEF,
    parameter logic [15:0] MAX_DATA_LEN   = 16'd4096,
    parameter int          TIMEOUT_CYCLES = 1024
`ifdef MSG_RECV_DES_FILTER_EN
    ,
    parameter logic [7:0]  LOCAL_ID       = 8'h01
`endif
) (
    input  logic         sys_clk_i,
    input  logic         rst_n_i,
    input  logic         flow_valid_i,
    input  logic [127:0] flow_data_i,
    input  logic         pl_full_i,
    output logic         pl_valid_o,
    output logic [127:0] pl_data_o,
    output logic [15:0]  pl_keep_o,
    output logic         pl_last_o,
    output logic         frame_done_o,
    output logic         frame_ok_o,
    output logic [3:0]   frame_err_o,
    output logic [3:0]   rx_frame_type_o,
    output logic [15:0]  rx_frame_cnt_o,
    output logic [7:0]   rx_src_id_o,
    output logic [7:0]   rx_des_id_o,
    output logic [7:0]   rx_data_type_o,
    output logic [7:0]   rx_data_channel_o,
    output logic [15:0]  rx_data_len_o,
    output logic [15:0]  sync_err_cnt_o
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [18:0]        wcnt_q, n_q;
    logic [15:0]        rem_q;
    logic [GAP_W-1:0]   gap_q;
    logic [7:0]         sum_q, ck_q;
    logic [3:0]         err_q, err_out_q;
    logic               drop_q, done_q;

    logic [15:0] hdr_len, hdr_flen, keep_cur, sum_mask;
    logic [7:0]  hdr_des, lane_sum;
    logic        hunting, sync_hit, len_bad, des_ok, last_word, timeout, ovf_now;
    logic [3:0]  chk_err, tmo_err;

    assign hdr_len   = flow_data_i[HDR_LEN_LSB +: 16];
    assign hdr_flen  = flow_data_i[HDR_FLEN_LSB +: 16];
    assign hdr_des   = flow_data_i[HDR_DES_LSB +: 8];
    assign hunting   = (state_q != S_BODY);
    assign sync_hit  = flow_valid_i && (flow_data_i[HDR_SYNC_LSB +: 32] == SYNC_HEADER);
    assign len_bad   = (hdr_flen != {5'd0, exp_frame_len(hdr_len)}) || (hdr_len > MAX_DATA_LEN);
    assign last_word = (state_q == S_BODY) && flow_valid_i && (wcnt_q == n_q - 19'd1);
    assign timeout   = (state_q == S_BODY) && !flow_valid_i
                       && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
    assign ovf_now   = pl_valid_o && pl_full_i;

`ifdef MSG_RECV_DES_FILTER_EN
    assign des_ok = (hdr_des == LOCAL_ID) || (hdr_des == 8'hFF);
`else
    assign des_ok = 1'b1;
`endif

    // rem_q counts payload bytes still to come; lanes at index >= len are masked.
    assign keep_cur = (rem_q >= 16'd16) ? 16'hFFFF : ~(16'hFFFF >> rem_q[3:0]);
    // The checksum byte (lane 0 of the final word) never enters the running sum.
    assign sum_mask = hunting ? 16'hFFFF
                              : (keep_cur & (last_word ? 16'hFFFE : 16'hFFFF));

    msg_byte_sum16 u_sum (
        .word      (flow_data_i),
        .lane_mask (sum_mask),
        .sum       (lane_sum)
    );

    always_comb begin
        chk_err           = err_q;
        chk_err[ERR_OVF]  = err_q[ERR_OVF] | ovf_now;
        chk_err[ERR_CSUM] = (sum_q != ck_q);
        tmo_err           = err_q;
        tmo_err[ERR_TMO]  = 1'b1;
    end

    // S_CHECK reports combinationally so the last payload write's overflow is included.
    assign frame_done_o = done_q || ((state_q == S_CHECK) && !drop_q);
    assign frame_err_o  = (state_q == S_CHECK) ? chk_err : err_out_q;
    assign frame_ok_o   = frame_done_o && !(|frame_err_o);

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_HUNT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT, S_CHECK: state_d = (sync_hit && !len_bad) ? S_BODY : S_HUNT;
            S_BODY: begin
                if (last_word)    state_d = S_CHECK;
                else if (timeout) state_d = S_HUNT;
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pl_valid_o        <= 1'b0;
            pl_data_o         <= '0;
            pl_keep_o         <= '0;
            pl_last_o         <= 1'b0;
            rx_frame_type_o   <= '0;
            rx_frame_cnt_o    <= '0;
            rx_src_id_o       <= '0;
            rx_des_id_o       <= '0;
            rx_data_type_o    <= '0;
            rx_data_channel_o <= '0;
            rx_data_len_o     <= '0;
            sync_err_cnt_o    <= '0;
            wcnt_q            <= '0;
            n_q               <= '0;
            rem_q             <= '0;
            gap_q             <= '0;
            sum_q             <= '0;
            ck_q              <= '0;
            err_q             <= '0;
            err_out_q         <= '0;
            drop_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            pl_valid_o <= 1'b0;
            pl_last_o  <= 1'b0;
            done_q     <= 1'b0;
            if (state_q == S_CHECK) err_out_q <= chk_err;

            if (hunting && flow_valid_i) begin
                if (!sync_hit) begin
                    if (sync_err_cnt_o != 16'hFFFF) sync_err_cnt_o <= sync_err_cnt_o + 16'd1;
                end else begin
                    if (des_ok) begin
                        rx_frame_type_o   <= flow_data_i[HDR_TYPE_LSB +: 4];
                        rx_frame_cnt_o    <= flow_data_i[HDR_CNT_LSB +: 16];
                        rx_src_id_o       <= flow_data_i[HDR_SRC_LSB +: 8];
                        rx_des_id_o       <= hdr_des;
                        rx_data_type_o    <= flow_data_i[HDR_DTYPE_LSB +: 8];
                        rx_data_channel_o <= flow_data_i[HDR_CHAN_LSB +: 8];
                        rx_data_len_o     <= hdr_len;
                    end
                    sum_q  <= lane_sum;
                    rem_q  <= hdr_len;
                    n_q    <= frame_words(hdr_len);
                    wcnt_q <= 19'd1;
                    gap_q  <= '0;
                    err_q  <= '0;
                    drop_q <= !des_ok;
                    if (len_bad && des_ok) begin
                        done_q             <= 1'b1;
                        err_out_q          <= '0;
                        err_out_q[ERR_LEN] <= 1'b1;
                    end
                end
            end

            if (state_q == S_BODY) begin
                if (ovf_now) err_q[ERR_OVF] <= 1'b1;
                if (flow_valid_i) begin
                    gap_q  <= '0;
                    wcnt_q <= wcnt_q + 19'd1;
                    sum_q  <= sum_q + lane_sum;
                    if (last_word) ck_q <= flow_data_i[7:0];
                    if (rem_q != 16'd0) begin
                        pl_valid_o <= !drop_q;
                        pl_data_o  <= flow_data_i;
                        pl_keep_o  <= keep_cur;
                        pl_last_o  <= (rem_q <= 16'd16);
                        rem_q      <= (rem_q >= 16'd16) ? rem_q - 16'd16 : 16'd0;
                    end
                end else begin
                    gap_q <= gap_q + 1'b1;
                    if (timeout) begin
                        done_q    <= !drop_q;
                        err_out_q <= tmo_err;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_receive_parser.sv
// Directed, table-driven bench for msg_receive_parser: frame vectors plus
// hand-written timeout, back-to-back/overflow and mid-frame reset sequences.
module tb_msg_receive_parser;

    localparam logic [31:0] SYNC = 32'hEB90_146F;
    localparam int          TMO  = 1024;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flow_valid;
    logic [127:0] flow_data;
    logic         pl_full;
    logic         pl_valid, pl_last, frame_done, frame_ok;
    logic [127:0] pl_data;
    logic [15:0]  pl_keep;
    logic [3:0]   frame_err, rx_frame_type;
    logic [15:0]  rx_frame_cnt, rx_data_len, sync_err_cnt;
    logic [7:0]   rx_src_id, rx_des_id, rx_data_type, rx_data_channel;

    msg_receive_parser dut (
        .sys_clk_i         (clk),
        .rst_n_i           (rst_n),
        .flow_valid_i      (flow_valid),
        .flow_data_i       (flow_data),
        .pl_full_i         (pl_full),
        .pl_valid_o        (pl_valid),
        .pl_data_o         (pl_data),
        .pl_keep_o         (pl_keep),
        .pl_last_o         (pl_last),
        .frame_done_o      (frame_done),
        .frame_ok_o        (frame_ok),
        .frame_err_o       (frame_err),
        .rx_frame_type_o   (rx_frame_type),
        .rx_frame_cnt_o    (rx_frame_cnt),
        .rx_src_id_o       (rx_src_id),
        .rx_des_id_o       (rx_des_id),
        .rx_data_type_o    (rx_data_type),
        .rx_data_channel_o (rx_data_channel),
        .rx_data_len_o     (rx_data_len),
        .sync_err_cnt_o    (sync_err_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    typedef struct { logic [127:0] data; logic [15:0] keep; logic last; } pl_t;
    typedef struct { logic ok; logic [3:0] err; int cyc; } done_t;

    pl_t   got_pl_q[$];
    done_t got_done_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (pl_valid)   got_pl_q.push_back('{pl_data, pl_keep, pl_last});
            if (frame_done) got_done_q.push_back('{frame_ok, frame_err, cyc});
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    logic [127:0] frame_q[$];
    int drive_cyc;

    task automatic send_word(input logic [127:0] w);
        @(negedge clk);
        flow_valid = 1'b1;
        flow_data  = w;
        drive_cyc  = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            flow_valid = 1'b0;
            flow_data  = '0;
        end
    endtask

    function automatic logic [7:0] bsum(input logic [127:0] w);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 16; k++) s = s + w[8*k +: 8];
        return s;
    endfunction

    // Payload byte i = i+1, padding 0xA5, checksum at [7:0] of the last word.
    task automatic build_frame(input logic [15:0] len, input logic [15:0] flen,
                               input logic [7:0] ck_delta, input logic [15:0] cnt,
                               output int n);
        logic [16:0]  t;
        logic [127:0] w;
        logic [7:0]   ck;
        int           wi, off;
        t = {1'b0, len} + 17'd16;
        n = (int'(t[16:6]) + 1) * 4;
        frame_q.delete();
        w = {SYNC, flen, 12'h000, 4'h3, cnt, 8'h22, 8'h01, 8'h44, 8'h55, len};
        frame_q.push_back(w);
        ck = bsum(w);
        for (int i = 1; i < n; i++) frame_q.push_back({16{8'hA5}});
        for (int i = 0; i < int'(len); i++) begin
            wi = 1 + i / 16;
            off = 8 * (15 - i % 16);
            w = frame_q[wi];
            w[off +: 8] = 8'(i + 1);
            frame_q[wi] = w;
            ck = ck + 8'(i + 1);
        end
        w = frame_q[n-1];
        w[7:0] = ck + ck_delta;
        frame_q[n-1] = w;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] len;
        logic [15:0] flen;
        logic [7:0]  ck_delta;
        int          exp_pl;
        logic [15:0] exp_last_keep;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check_frame(input string tag, input int exp_pl, input logic [15:0] last_keep,
                               input logic [3:0] exp_err, input int last_cyc);
        check({tag, "_done_cnt"}, 128'(got_done_q.size()), 128'd1);
        if (got_done_q.size() > 0) begin
            check({tag, "_err"}, 128'(got_done_q[0].err), 128'(exp_err));
            check({tag, "_ok"}, 128'(got_done_q[0].ok), 128'(exp_err == 4'd0));
            check({tag, "_latency"}, 128'(got_done_q[0].cyc), 128'(last_cyc + 1));
        end
        check({tag, "_pl_cnt"}, 128'(got_pl_q.size()), 128'(exp_pl));
        exp_q.delete();
        for (int w = 1; w <= exp_pl; w++) exp_q.push_back(frame_q[w]);
        for (int k = 0; k < got_pl_q.size() && k < exp_pl; k++) begin
            check({tag, "_pl_data"}, got_pl_q[k].data, exp_q.pop_front());
            check({tag, "_pl_keep"}, 128'(got_pl_q[k].keep),
                  (k == exp_pl - 1) ? 128'(last_keep) : 128'hFFFF);
            check({tag, "_pl_last"}, 128'(got_pl_q[k].last), 128'(k == exp_pl - 1));
        end
    endtask

    initial begin
        int n, a_last, b_hdr;
        logic [127:0] fa[$];
        logic [127:0] fb[$];

        vecs[0] = '{16'd5,    16'd0,  8'd0, 1, 16'hF800, 4'b0000};
        vecs[1] = '{16'd48,   16'd1,  8'd0, 3, 16'hFFFF, 4'b0000};
        vecs[2] = '{16'd47,   16'd0,  8'd0, 3, 16'hFFFE, 4'b0000};
        vecs[3] = '{16'd0,    16'd0,  8'd0, 0, 16'h0000, 4'b0000};
        vecs[4] = '{16'd5,    16'd0,  8'd1, 1, 16'hF800, 4'b0001};
        vecs[5] = '{16'd5,    16'd2,  8'd0, 0, 16'h0000, 4'b0010};
        vecs[6] = '{16'd5,    16'd0,  8'd0, 1, 16'hF800, 4'b0000};
        vecs[7] = '{16'd100,  16'd1,  8'd0, 7, 16'hF000, 4'b0000};
        vecs[8] = '{16'd4097, 16'd64, 8'd0, 0, 16'h0000, 4'b0010};

        rst_n      = 1'b0;
        flow_valid = 1'b0;
        flow_data  = '0;
        pl_full    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pl_valid", 128'(pl_valid), 128'd0);
        check("rst_frame_done", 128'(frame_done), 128'd0);
        check("rst_frame_ok", 128'(frame_ok), 128'd0);
        check("rst_frame_err", 128'(frame_err), 128'd0);
        check("rst_sync_err_cnt", 128'(sync_err_cnt), 128'd0);
        check("rst_rx_data_len", 128'(rx_data_len), 128'd0);
        rst_n = 1'b1;
        idle(2);

        // Junk words while hunting.
        send_word({32'hDEAD_BEEF, 96'h1});
        send_word({32'hEB90_146E, 96'h2});
        send_word(128'h0);
        idle(3);
        check("junk_sync_err_cnt", 128'(sync_err_cnt), 128'd3);
        check("junk_no_done", 128'(got_done_q.size()), 128'd0);

        for (int i = 0; i < 9; i++) begin
            got_pl_q.delete();
            got_done_q.delete();
            build_frame(vecs[i].len, vecs[i].flen, vecs[i].ck_delta, 16'h1000 + 16'(i), n);
            if (vecs[i].exp_err[1]) send_word(frame_q[0]);
            else for (int w = 0; w < n; w++) send_word(frame_q[w]);
            a_last = drive_cyc;
            idle(4);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_pl, vecs[i].exp_last_keep,
                        vecs[i].exp_err, a_last);
            check($sformatf("vec%0d_rx_len", i), 128'(rx_data_len), 128'(vecs[i].len));
            check($sformatf("vec%0d_rx_cnt", i), 128'(rx_frame_cnt), 128'(16'h1000 + 16'(i)));
        end

        // Timeout after word 2 of an N=8 frame.
        got_pl_q.delete();
        got_done_q.delete();
        build_frame(16'd48, 16'd1, 8'd0, 16'h2000, n);
        for (int w = 0; w < 3; w++) send_word(frame_q[w]);
        idle(TMO + 10);
        check("tmo_done_cnt", 128'(got_done_q.size()), 128'd1);
        if (got_done_q.size() > 0) begin
            check("tmo_err", 128'(got_done_q[0].err), 128'b0100);
            check("tmo_ok", 128'(got_done_q[0].ok), 128'd0);
        end
        check("tmo_pl_cnt", 128'(got_pl_q.size()), 128'd2);
        got_pl_q.delete();
        got_done_q.delete();
        build_frame(16'd5, 16'd0, 8'd0, 16'h2001, n);
        for (int w = 0; w < n; w++) send_word(frame_q[w]);
        a_last = drive_cyc;
        idle(4);
        check_frame("post_tmo", 1, 16'hF800, 4'b0000, a_last);

        // Back-to-back frames, FIFO full during the second.
        got_pl_q.delete();
        got_done_q.delete();
        build_frame(16'd5, 16'd0, 8'd0, 16'hA001, n);
        fa = frame_q;
        build_frame(16'd5, 16'd0, 8'd0, 16'hB002, n);
        fb = frame_q;
        for (int w = 0; w < 4; w++) send_word(fa[w]);
        a_last = drive_cyc;
        send_word(fb[0]);
        b_hdr = drive_cyc;
        pl_full = 1'b1;
        for (int w = 1; w < 4; w++) send_word(fb[w]);
        idle(4);
        pl_full = 1'b0;
        check("b2b_done_cnt", 128'(got_done_q.size()), 128'd2);
        if (got_done_q.size() > 1) begin
            check("b2b_a_err", 128'(got_done_q[0].err), 128'b0000);
            check("b2b_a_ok", 128'(got_done_q[0].ok), 128'd1);
            check("b2b_a_latency", 128'(got_done_q[0].cyc), 128'(a_last + 1));
            check("b2b_a_with_b_hdr", 128'(got_done_q[0].cyc), 128'(b_hdr));
            check("b2b_b_err", 128'(got_done_q[1].err), 128'b1000);
            check("b2b_b_ok", 128'(got_done_q[1].ok), 128'd0);
        end
        check("b2b_pl_cnt", 128'(got_pl_q.size()), 128'd2);
        check("b2b_rx_cnt", 128'(rx_frame_cnt), 128'hB002);
        check("final_sync_err_cnt", 128'(sync_err_cnt), 128'd3);

        // Reset in the middle of a frame.
        build_frame(16'd48, 16'd1, 8'd0, 16'hC003, n);
        send_word(frame_q[0]);
        send_word(frame_q[1]);
        @(negedge clk);
        flow_valid = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        got_pl_q.delete();
        got_done_q.delete();
        idle(6);
        check("midrst_no_done", 128'(got_done_q.size()), 128'd0);
        check("midrst_rx_len", 128'(rx_data_len), 128'd0);
        check("midrst_sync_err_cnt", 128'(sync_err_cnt), 128'd0);
        build_frame(16'd5, 16'd0, 8'd0, 16'hC004, n);
        for (int w = 0; w < n; w++) send_word(frame_q[w]);
        a_last = drive_cyc;
        idle(4);
        check_frame("post_rst", 1, 16'hF800, 4'b0000, a_last);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
